gen_counter: RTL and testbench
==============================

GEN_COUNTER -- requirements
Module: gen_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, counter/step/limit width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load  input  1  parallel load strobe.
REQ-005 SHALL have port cnt_in  input  WIDTH  load value.
REQ-006 SHALL have port enab  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port step  input  WIDTH  increment/decrement amount.
REQ-009 SHALL have port limit  input  WIDTH  upper bound of count range.
REQ-010 SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 hold.
REQ-011 SHALL have port ovf_clr  input  1  clears sticky overflow flag.
REQ-012 SHALL have port cnt_out  output  WIDTH  registered count.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port ovf  output  1  sticky boundary-event flag.
REQ-015 SHALL have port halted  output  1  one-shot completion state.

Function
REQ-016 All outputs SHALL be registered on the rising edge of clk; priority: rst > load > count.
REQ-017 The boundary event SHALL be defined as a count cycle with up=1 and (cnt_out+step) > limit (evaluated WIDTH+1 bits, no truncation), or with up=0 and cnt_out < step.
REQ-018 A count cycle SHALL be enab=1, load=0, halted=0, mode != 11.
REQ-019 In a count cycle without boundary event, cnt_out SHALL become cnt_out+step (up) or cnt_out-step (down).
REQ-020 Wrap mode, boundary event: cnt_out SHALL become 0 (up) or limit (down).
REQ-021 Saturate mode, boundary event: cnt_out SHALL become limit (up) or 0 (down); a repeated event while held at the bound SHALL pulse tc each cycle.
REQ-022 One-shot mode, boundary event: cnt_out SHALL become limit (up) or 0 (down) and halted SHALL become 1.
REQ-023 While halted=1, cnt_out SHALL hold regardless of enab, up, step or mode.
REQ-024 halted SHALL clear only on load or rst.
REQ-025 tc SHALL be 1 for exactly the cycle following each boundary event (coincident with the updated cnt_out), else 0.
REQ-026 ovf SHALL set on any boundary event and SHALL clear on ovf_clr; simultaneous set and clear SHALL leave ovf=1.
REQ-027 load=1 SHALL set cnt_out=cnt_in, halted=0, tc=0, ignoring enab; ovf is unaffected by load.
REQ-028 Mode 11 or enab=0 SHALL hold cnt_out with tc=0.
REQ-029 cnt_in > limit SHALL be accepted as loaded; the next up count cycle SHALL be a boundary event.
REQ-030 step=0 SHALL produce no change and no event unless cnt_out > limit (up).
REQ-031 Changes on mode, up, step or limit SHALL take effect on the first count cycle in which they are sampled; no internal state other than outputs SHALL be retained.

Reset
REQ-032 On rst=1: cnt_out=0, tc=0, ovf=0, halted=0, overriding load, enab and ovf_clr.
REQ-033 Reset asserted mid-count or while halted SHALL return all outputs to reset values in the next cycle.

Verification (WIDTH=5)
REQ-034 Wrap up: limit=9, step=3, mode=00, up=1, from load 0 -> cnt_out 3, 6, 9, 0; tc=1 only with 0; ovf=1 afterwards.
REQ-035 Down saturate: limit=20, step=4, mode=01, up=0, load 6 -> cnt_out 2, 0, 0; tc=1 on both 0 cycles.
REQ-036 One-shot: limit=31, step=8, mode=10, up=1, load 20 -> 28, 31 with tc=1, halted=1; further enab holds 31; load 5 -> cnt_out 5, halted=0.
REQ-037 Priority: load=1 and enab=1 with cnt_in=17 -> cnt_out 17, tc=0; rst with load -> cnt_out 0.
REQ-038 Flag race: boundary event with ovf_clr=1 simultaneously -> ovf=1; ovf_clr next cycle alone -> ovf=0.
REQ-039 Out-of-range load: limit=10, load 25, up=1, step=1, mode=00 -> cnt_out 0, tc=1.

Source files
------------

// File: rtl/gen_counter_if.sv
// Request/status bundle for gen_counter: control inputs from the master, registered count state back.
// Master drives load/count controls; slave (the counter) drives cnt_out/tc/ovf/halted.
interface gen_counter_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] cnt_in;
  logic             enab;
  logic             up;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             ovf;
  logic             halted;

  modport master (
    output load, cnt_in, enab, up, step, limit, mode, ovf_clr,
    input  cnt_out, tc, ovf, halted
  );

  modport slave (
    input  load, cnt_in, enab, up, step, limit, mode, ovf_clr,
    output cnt_out, tc, ovf, halted
  );
endinterface

// File: rtl/gen_counter.sv
// Up/down step counter with wrap/saturate/one-shot/hold modes, terminal-count pulse and sticky flag.
// One-cycle latency, all outputs registered; no backpressure, every count cycle is accepted.
module gen_counter #(
  parameter int WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  gen_counter_if.slave  bus
);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_ovf;
  logic             r_halted;

  logic             w_count;
  logic [WIDTH:0]   w_sum;
  logic             w_up_evt;
  logic             w_dn_evt;
  logic             w_evt;

  // The sum is kept one bit wider so an overflow past 2^WIDTH still counts as crossing limit.
  assign w_count  = bus.enab && !bus.load && !r_halted && (bus.mode != MODE_HOLD);
  assign w_sum    = {1'b0, r_cnt} + {1'b0, bus.step};
  assign w_up_evt = w_sum > {1'b0, bus.limit};
  assign w_dn_evt = r_cnt < bus.step;
  assign w_evt    = w_count && (bus.up ? w_up_evt : w_dn_evt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_tc     <= 1'b0;
      r_ovf    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_tc <= w_evt;
      if (w_evt)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf <= 1'b0;

      if (bus.load) begin
        r_cnt    <= bus.cnt_in;
        r_halted <= 1'b0;
      end else if (w_evt) begin
        case (bus.mode)
          MODE_WRAP: r_cnt <= bus.up ? '0 : bus.limit;
          MODE_SAT:  r_cnt <= bus.up ? bus.limit : '0;
          MODE_ONE: begin
            r_cnt    <= bus.up ? bus.limit : '0;
            r_halted <= 1'b1;
          end
          default:   r_cnt <= r_cnt;
        endcase
      end else if (w_count) begin
        r_cnt <= bus.up ? w_sum[WIDTH-1:0] : (r_cnt - bus.step);
      end
    end
  end

  assign bus.cnt_out = r_cnt;
  assign bus.tc      = r_tc;
  assign bus.ovf     = r_ovf;
  assign bus.halted  = r_halted;

endmodule

// File: tb/tb_gen_counter.sv
// Table-driven bench for gen_counter (WIDTH=5): each vector's expected outputs are queued when
// driven and popped after the following rising edge.
module tb_gen_counter;

  localparam int W = 5;

  logic clk;
  logic rst;

  gen_counter_if #(.WIDTH(W)) bus ();

  gen_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         load;
    logic [W-1:0] cnt_in;
    logic         enab;
    logic         up;
    logic [W-1:0] step;
    logic [W-1:0] limit;
    logic [1:0]   mode;
    logic         ovf_clr;
    logic [W-1:0] e_cnt;
    logic         e_tc;
    logic         e_ovf;
    logic         e_halted;
  } vec_t;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
    logic         halted;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic ld, input int cin, input logic en,
                              input logic u, input int st, input int lim, input int md,
                              input logic oc, input int ec, input logic etc,
                              input logic eovf, input logic eh);
    vec_t v;
    v.rst = r; v.load = ld; v.cnt_in = W'(cin); v.enab = en; v.up = u;
    v.step = W'(st); v.limit = W'(lim); v.mode = 2'(md); v.ovf_clr = oc;
    v.e_cnt = W'(ec); v.e_tc = etc; v.e_ovf = eovf; v.e_halted = eh;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, want %0d", name, idx, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst         = v.rst;
    bus.load    = v.load;
    bus.cnt_in  = v.cnt_in;
    bus.enab    = v.enab;
    bus.up      = v.up;
    bus.step    = v.step;
    bus.limit   = v.limit;
    bus.mode    = v.mode;
    bus.ovf_clr = v.ovf_clr;
    e.cnt = v.e_cnt; e.tc = v.e_tc; e.ovf = v.e_ovf; e.halted = v.e_halted;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue, want one entry", idx);
    end else begin
      g = exp_q.pop_front();
      check("cnt_out", idx, int'(bus.cnt_out), int'(g.cnt));
      check("tc",      idx, int'(bus.tc),      int'(g.tc));
      check("ovf",     idx, int'(bus.ovf),     int'(g.ovf));
      check("halted",  idx, int'(bus.halted),  int'(g.halted));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.cnt_in = '0; bus.enab = 1'b0; bus.up = 1'b1;
    bus.step = '0; bus.limit = '0; bus.mode = 2'b00; bus.ovf_clr = 1'b0;

    //              rst ld cin en up st lim md oc | cnt tc ovf h
    vecs.push_back(mk(1, 0,  0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0)); // reset state
    vecs.push_back(mk(0, 1,  0, 0, 1, 3,  9, 0, 0,  0, 0, 0, 0)); // wrap up
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 0, 0,  3, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 0, 0,  6, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 0, 0,  9, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0, 1, 3,  9, 0, 0,  0, 0, 1, 0)); // enab=0 holds
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 3, 0,  0, 0, 1, 0)); // mode 11 holds
    vecs.push_back(mk(0, 0,  0, 0, 1, 3,  9, 0, 1,  0, 0, 0, 0)); // ovf_clr
    vecs.push_back(mk(0, 1,  6, 0, 0, 4, 20, 1, 0,  6, 0, 0, 0)); // down saturate
    vecs.push_back(mk(0, 0,  0, 1, 0, 4, 20, 1, 0,  2, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 4, 20, 1, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 4, 20, 1, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 18, 0, 1, 4, 20, 1, 0, 18, 0, 1, 0)); // up saturate, load keeps ovf
    vecs.push_back(mk(0, 0,  0, 1, 1, 4, 20, 1, 0, 20, 1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 1, 4, 20, 1, 0, 20, 1, 1, 0));
    vecs.push_back(mk(0, 1, 20, 0, 1, 8, 31, 2, 0, 20, 0, 1, 0)); // one-shot
    vecs.push_back(mk(0, 0,  0, 1, 1, 8, 31, 2, 0, 28, 0, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 1, 8, 31, 2, 0, 31, 1, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0, 3, 31, 0, 0, 31, 0, 1, 1)); // halted holds
    vecs.push_back(mk(0, 1,  5, 0, 1, 8, 31, 2, 0,  5, 0, 1, 0));
    vecs.push_back(mk(0, 1, 17, 1, 1, 1, 31, 0, 0, 17, 0, 1, 0)); // load beats enab
    vecs.push_back(mk(1, 1,  9, 1, 1, 1, 31, 0, 1,  0, 0, 0, 0)); // rst beats load
    vecs.push_back(mk(0, 1,  8, 0, 1, 3,  9, 0, 0,  8, 0, 0, 0)); // flag race
    vecs.push_back(mk(0, 0,  0, 1, 1, 3,  9, 0, 1,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0, 1, 3,  9, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 25, 0, 1, 1, 10, 0, 0, 25, 0, 0, 0)); // out-of-range load
    vecs.push_back(mk(0, 0,  0, 1, 1, 1, 10, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1,  4, 0, 1, 0, 10, 0, 0,  4, 0, 1, 0)); // step 0 in range
    vecs.push_back(mk(0, 0,  0, 1, 1, 0, 10, 0, 0,  4, 0, 1, 0));
    vecs.push_back(mk(0, 1, 15, 0, 1, 0, 10, 0, 1, 15, 0, 0, 0)); // step 0 above limit
    vecs.push_back(mk(0, 0,  0, 1, 1, 0, 10, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1,  2, 0, 0, 3, 10, 0, 0,  2, 0, 1, 0)); // down wrap
    vecs.push_back(mk(0, 0,  0, 1, 0, 3, 10, 0, 0, 10, 1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 3, 10, 0, 0,  7, 0, 1, 0));
    vecs.push_back(mk(0, 1,  1, 0, 0, 2, 10, 2, 0,  1, 0, 1, 0)); // one-shot down then reset
    vecs.push_back(mk(0, 0,  0, 1, 0, 2, 10, 2, 0,  0, 1, 1, 1));
    vecs.push_back(mk(0, 0,  0, 1, 0, 2, 10, 2, 0,  0, 0, 1, 1));
    vecs.push_back(mk(1, 0,  0, 1, 0, 2, 10, 2, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0, 2, 10, 2, 0,  0, 1, 1, 1));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Full-range unit-step wrap: 31 plain increments, then 31+1 crosses limit=31 and wraps to 0.
    apply(mk(0, 1, 0, 0, 1, 1, 31, 0, 1, 0, 0, 0, 0), 100);
    for (int k = 1; k <= 31; k++)
      apply(mk(0, 0, 0, 1, 1, 1, 31, 0, 0, k, 0, 0, 0), 100 + k);
    apply(mk(0, 0, 0, 1, 1, 1, 31, 0, 0, 0, 1, 1, 0), 132);

    // Mid-count reset.
    apply(mk(0, 0, 0, 1, 1, 1, 31, 0, 0, 1, 0, 1, 0), 133);
    apply(mk(1, 0, 0, 1, 1, 1, 31, 0, 0, 0, 0, 0, 0), 134);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: got %0d left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
